// File: rtl/reset_pulser_if.sv
// reset_pulser_if: trigger/sequence bus between a controller and reset_pulser
interface reset_pulser_if #(parameter int CNT_WIDTH = 32);
   logic                 trig;
   logic                 abort;
   logic [CNT_WIDTH-1:0] delay;
   logic [CNT_WIDTH-1:0] width;
   logic                 pulse_out;
   logic                 busy;
   logic                 done;
   modport master (output trig, abort, delay, width, input pulse_out, busy, done);
   modport slave (input trig, abort, delay, width, output pulse_out, busy, done);
endinterface

// File: rtl/reset_pulser.sv
// reset_pulser: programmable delay-then-pulse generator with abort and done strobe
module reset_pulser #(
   parameter int CNT_WIDTH  = 32,
   parameter int ACTIVE_LOW = 1
) (
   input logic            clk,
   input logic            rst,
   reset_pulser_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, DELAY, PULSE, DONE} state_t;
   localparam logic INACT = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
   localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
   state_t               st = IDLE;
   state_t               nxt;
   logic [CNT_WIDTH-1:0] cnt = '0;
   logic [CNT_WIDTH-1:0] w_q = '0;
   logic [CNT_WIDTH-1:0] cnt_n, w_n;
   logic                 pulse_q = INACT;
   logic                 busy_q = 1'b0;
   logic                 done_q = 1'b0;
   // counter holds cycles remaining in the current phase, so max values never wrap
   always_comb begin
      nxt   = st;
      cnt_n = cnt;
      w_n   = w_q;
      case (st)
         IDLE: if (bus.trig && !bus.abort) begin
            w_n   = bus.width;
            nxt   = (bus.delay != '0) ? DELAY : (bus.width != '0) ? PULSE : DONE;
            cnt_n = (bus.delay != '0) ? bus.delay : bus.width;
         end
         DELAY: begin
            nxt   = bus.abort ? IDLE : (cnt != ONE) ? DELAY : (w_q != '0) ? PULSE : DONE;
            cnt_n = bus.abort ? '0 : (cnt != ONE) ? cnt - ONE : w_q;
         end
         PULSE: begin
            nxt   = bus.abort ? IDLE : (cnt != ONE) ? PULSE : DONE;
            cnt_n = (bus.abort || cnt == ONE) ? '0 : cnt - ONE;
         end
         default: begin
            nxt   = IDLE;
            cnt_n = '0;
         end
      endcase
   end
   // outputs are registered from the next state so they line up with the state they describe
   always_ff @(posedge clk) begin
      if (rst) begin
         st      <= IDLE;
         cnt     <= '0;
         w_q     <= '0;
         pulse_q <= INACT;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         st      <= nxt;
         cnt     <= cnt_n;
         w_q     <= w_n;
         pulse_q <= (nxt == PULSE) ? ~INACT : INACT;
         busy_q  <= (nxt == DELAY) || (nxt == PULSE);
         done_q  <= (nxt == DONE);
      end
   end
   assign bus.pulse_out = pulse_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
endmodule
